// File: rtl/hilo_unit_if.sv
// Bus bundle for hilo_unit: op strobe, operands, and the HI/LO/busy/done results.
// The pipeline side uses the master modport and the HI/LO unit uses the slave modport.
interface hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] alu_hi;
  logic [WIDTH-1:0] alu_lo;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output valid, op, alu_hi, alu_lo, rs_data, rt_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  valid, op, alu_hi, alu_lo, rs_data, rt_data,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with wprod/mthi/mtlo writes and, when HILO_DIV_EN is defined,
// an iterative restoring divider (remainder->HI, quotient->LO) that stalls upstream via busy.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  hilo_unit_if.slave bus
);
  localparam logic [2:0] OP_WPROD = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

`ifdef HILO_DIV_EN
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quot_fix;

  always_comb begin
    a_neg  = (bus.op == OP_DIV) && bus.rs_data[WIDTH-1];
    b_neg  = (bus.op == OP_DIV) && bus.rt_data[WIDTH-1];
    a_abs  = a_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    b_abs  = b_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
    // Restoring step: the WIDTH+1-bit trial difference keeps the carry-out of the shifted remainder.
    shifted = {rem_q, quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_d  = trial[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d  = shifted[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b0};
    end
    rem_fix  = neg_rem_q  ? (~rem_q  + 1'b1) : rem_q;
    quot_fix = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.valid) begin
            case (bus.op)
              OP_WPROD: begin
                hi_q <= bus.alu_hi;
                lo_q <= bus.alu_lo;
              end
              OP_MTHI: hi_q <= bus.rs_data;
              OP_MTLO: lo_q <= bus.rs_data;
              OP_DIV, OP_DIVU: begin
                cnt_q <= '0;
                if (bus.rt_data == '0) begin
                  // Divide by zero bypasses RUN: FIX writes the raw dividend and an all-ones quotient.
                  rem_q      <= bus.rs_data;
                  quot_q     <= '1;
                  dvsr_q     <= '0;
                  neg_quot_q <= 1'b0;
                  neg_rem_q  <= 1'b0;
                  state_q    <= FIX;
                end else begin
                  rem_q      <= '0;
                  quot_q     <= a_abs;
                  dvsr_q     <= b_abs;
                  neg_quot_q <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  state_q    <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= rem_fix;
          lo_q    <= quot_fix;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign bus.busy = 1'b0;
  assign bus.done = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (bus.valid) begin
      case (bus.op)
        OP_WPROD: begin
          hi_q <= bus.alu_hi;
          lo_q <= bus.alu_lo;
        end
        OP_MTHI: hi_q <= bus.rs_data;
        OP_MTLO: lo_q <= bus.rs_data;
        default: ;
      endcase
    end
  end
`endif
endmodule
